// File: rtl/depth_est_pkg.sv
// Shared types and constants for the depth-estimation input path:
// RGB pixel struct, default frame geometry and status-word layout.
package depth_est_pkg;

    localparam int IMG_W_DEFAULT    = 320;
    localparam int IMG_H_DEFAULT    = 240;

    localparam int STAT_SEQ_ERR_BIT = 31;
    localparam int STAT_BE_ERR_BIT  = 30;
    localparam int STAT_LEVEL_W     = 16;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_px_t;

    function automatic logic [31:0] status_word(
        input logic        seq_err,
        input logic        be_err,
        input logic [15:0] level
    );
        logic [31:0] w;
        w                           = '0;
        w[STAT_SEQ_ERR_BIT]         = seq_err;
        w[STAT_BE_ERR_BIT]          = be_err;
        w[STAT_LEVEL_W-1:0]         = level;
        return w;
    endfunction

endpackage

// File: rtl/rgb_in_fifo.sv
// Synchronous pixel FIFO with a registered output head. The head register
// counts as one of the DEPTH entries; level covers head plus memory.
module rgb_in_fifo
    import depth_est_pkg::*;
#(
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  rgb_px_t       push_data,
    input  logic          pop,
    output rgb_px_t       head_data,
    output logic          empty,
    output logic          full,
    output logic [LW-1:0] level
);

    rgb_px_t       mem [DEPTH];
    rgb_px_t       head_q;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [LW-1:0] mem_cnt;
    logic          valid_q, valid_d;
    logic          full_q, full_d;
    logic          push_ok, pop_ok, load;

    always_comb begin
        push_ok  = push && !full_q;
        pop_ok   = pop && valid_q;
        mem_cnt  = level_q - LW'(valid_q);
        // Refill the head from memory whenever it is free or being consumed.
        load     = (mem_cnt != '0) && (!valid_q || pop_ok);
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(load);
        level_d  = level_q + LW'(push_ok) - LW'(pop_ok);
        full_d   = (level_d == LW'(DEPTH));
        valid_d  = load || (valid_q && !pop_ok);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // Registered read port doubles as the stream output register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head_q <= '0;
        end else if (load) begin
            head_q <= mem[rd_ptr_q];
        end
    end

    assign head_data = head_q;
    assign empty     = !valid_q;
    assign full      = full_q;
    assign level     = level_q;

endmodule

// File: rtl/rgb_in_stream_bridge.sv
// Avalon-MM pixel sink -> ready/valid RGB stream with frame markers.
// Optional write-address sequence checking via RGB_IN_SEQ_CHECK_EN.
module rgb_in_stream_bridge
    import depth_est_pkg::*;
#(
    parameter int IMG_W      = IMG_W_DEFAULT,
    parameter int IMG_H      = IMG_H_DEFAULT,
    parameter int FIFO_DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [19:0] avl_address,
    input  logic        avl_write,
    input  logic [31:0] avl_writedata,
    input  logic [3:0]  avl_byteenable,
    input  logic        avl_read,
    output logic [31:0] avl_readdata,
    output logic        avl_readdatavalid,
    output logic        avl_waitrequest,
    input  logic        err_clr,
    output logic        px_valid,
    input  logic        px_ready,
    output logic [7:0]  px_r,
    output logic [7:0]  px_g,
    output logic [7:0]  px_b,
    output logic        px_sof,
    output logic        px_eol,
    output logic        px_eof
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    rgb_px_t       push_px, head_px;
    logic          fifo_empty, fifo_full;
    logic [LW-1:0] fifo_level;
    logic          wr_acc, px_push, be_bad, pop, seq_err;

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          be_err_q, be_err_d;
    logic [31:0]   readdata_q, readdata_d;
    logic          rdv_q, rdv_d;

    assign push_px         = rgb_px_t'(avl_writedata[23:0]);
    assign avl_waitrequest = fifo_full;
    assign wr_acc          = avl_write && !fifo_full;
    assign px_push         = wr_acc && (avl_byteenable == 4'hF);
    assign be_bad          = wr_acc && (avl_byteenable != 4'hF);
    assign px_valid        = !fifo_empty;
    assign pop             = px_valid && px_ready;

    rgb_in_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (px_push),
        .push_data (push_px),
        .pop       (pop),
        .head_data (head_px),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (fifo_level)
    );

`ifdef RGB_IN_SEQ_CHECK_EN
    localparam int FRAME_PX = IMG_W * IMG_H;

    logic [19:0] exp_addr_q, exp_addr_d;
    logic        seq_err_q, seq_err_d, seq_bad;
    logic        unused_bits;

    always_comb begin
        seq_bad    = px_push && (avl_address != exp_addr_q);
        exp_addr_d = exp_addr_q;
        // Resync to the host's address so one glitch flags once, not forever.
        if (px_push) begin
            exp_addr_d = (avl_address >= 20'(FRAME_PX - 1)) ? '0 : avl_address + 20'd1;
        end
        seq_err_d  = seq_bad ? 1'b1 : (err_clr ? 1'b0 : seq_err_q);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            exp_addr_q <= '0;
            seq_err_q  <= 1'b0;
        end else begin
            exp_addr_q <= exp_addr_d;
            seq_err_q  <= seq_err_d;
        end
    end

    assign seq_err     = seq_err_q;
    assign unused_bits = ^avl_writedata[31:24];
`else
    logic unused_bits;

    assign seq_err     = 1'b0;
    assign unused_bits = ^{avl_writedata[31:24], avl_address};
`endif

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (pop) begin
            if (x_q == XW'(IMG_W - 1)) begin
                x_d = '0;
                y_d = (y_q == YW'(IMG_H - 1)) ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
        be_err_d   = be_bad ? 1'b1 : (err_clr ? 1'b0 : be_err_q);
        rdv_d      = avl_read;
        readdata_d = avl_read ? status_word(seq_err, be_err_q, 16'(fifo_level)) : readdata_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            x_q        <= '0;
            y_q        <= '0;
            be_err_q   <= 1'b0;
            rdv_q      <= 1'b0;
            readdata_q <= '0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            be_err_q   <= be_err_d;
            rdv_q      <= rdv_d;
            readdata_q <= readdata_d;
        end
    end

    assign avl_readdata      = readdata_q;
    assign avl_readdatavalid = rdv_q;
    assign px_r              = head_px.r;
    assign px_g              = head_px.g;
    assign px_b              = head_px.b;
    // Markers are only meaningful alongside a valid pixel.
    assign px_sof            = px_valid && (x_q == '0) && (y_q == '0);
    assign px_eol            = px_valid && (x_q == XW'(IMG_W - 1));
    assign px_eof            = px_eol && (y_q == YW'(IMG_H - 1));

endmodule

// File: tb/tb_rgb_in_stream_bridge.sv
// Randomised + directed bench for rgb_in_stream_bridge against a queue-based
// model of the pixel path, error flags and status reads.
module tb_rgb_in_stream_bridge;
    import depth_est_pkg::*;

    localparam int W  = 320;
    localparam int H  = 240;
    localparam int D  = 64;
    localparam int FR = W * H;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [19:0] avl_address;
    logic        avl_write;
    logic [31:0] avl_writedata;
    logic [3:0]  avl_byteenable;
    logic        avl_read;
    logic [31:0] avl_readdata;
    logic        avl_readdatavalid;
    logic        avl_waitrequest;
    logic        err_clr;
    logic        px_valid;
    logic        px_ready;
    logic [7:0]  px_r, px_g, px_b;
    logic        px_sof, px_eol, px_eof;

    always #5 clk = ~clk;

    rgb_in_stream_bridge #(
        .IMG_W      (W),
        .IMG_H      (H),
        .FIFO_DEPTH (D)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .avl_address       (avl_address),
        .avl_write         (avl_write),
        .avl_writedata     (avl_writedata),
        .avl_byteenable    (avl_byteenable),
        .avl_read          (avl_read),
        .avl_readdata      (avl_readdata),
        .avl_readdatavalid (avl_readdatavalid),
        .avl_waitrequest   (avl_waitrequest),
        .err_clr           (err_clr),
        .px_valid          (px_valid),
        .px_ready          (px_ready),
        .px_r              (px_r),
        .px_g              (px_g),
        .px_b              (px_b),
        .px_sof            (px_sof),
        .px_eol            (px_eol),
        .px_eof            (px_eof)
    );

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: every accepted pixel carries the edge number it was written on;
    // it may be presented only from the following edge onward.
    typedef struct {
        logic [23:0] px;
        int          stamp;
    } ent_t;

    ent_t        q[$];
    ent_t        ent;
    int          t        = 0;
    int          popped   = 0;
    int          m_exp    = 0;
    bit          m_be     = 1'b0;
    bit          m_seq    = 1'b0;
    bit          m_wait   = 1'b0;
    bit          m_rdv    = 1'b0;
    logic [31:0] m_rdata  = '0;
    bit          started  = 1'b0;
    bit          vis, acc, be_bad, seq_bad;

    initial forever begin
        @(posedge clk);
        vis = (q.size() > 0) && (q[0].stamp < t);
        t++;
        if (!reset_n) begin
            q.delete();
            popped  = 0;
            m_exp   = 0;
            m_be    = 1'b0;
            m_seq   = 1'b0;
            m_wait  = 1'b0;
            m_rdv   = 1'b0;
            m_rdata = '0;
            started = 1'b1;
        end else begin
            acc     = avl_write && !m_wait;
            be_bad  = acc && (avl_byteenable != 4'hF);
            seq_bad = 1'b0;
            m_rdv   = avl_read;
            if (avl_read) m_rdata = {m_seq, m_be, 14'b0, 16'(q.size())};
            if (vis && px_ready) begin
                void'(q.pop_front());
                popped++;
            end
            if (acc && avl_byteenable == 4'hF) begin
`ifdef RGB_IN_SEQ_CHECK_EN
                if (int'(avl_address) != m_exp) seq_bad = 1'b1;
                m_exp = (int'(avl_address) >= FR - 1) ? 0 : int'(avl_address) + 1;
`endif
                ent.px    = avl_writedata[23:0];
                ent.stamp = t;
                q.push_back(ent);
            end
            if (be_bad) m_be = 1'b1;
            else if (err_clr) m_be = 1'b0;
            if (seq_bad) m_seq = 1'b1;
            else if (err_clr) m_seq = 1'b0;
            m_wait = (q.size() == D);
        end
    end

    bit frame_phase = 1'b0;
    int eof_cnt = 0, eol_cnt = 0, sof_cnt = 0;

    // Compare process: every cycle, DUT outputs versus the model.
    initial forever begin
        bit ev;
        int p;
        @(negedge clk);
        if (started) begin
            ev = (q.size() > 0) && (q[0].stamp < t);
            chk("waitrequest", 32'(avl_waitrequest), 32'(m_wait));
            chk("readdatavalid", 32'(avl_readdatavalid), 32'(m_rdv));
            chk("readdata", avl_readdata, m_rdata);
            chk("px_valid", 32'(px_valid), 32'(ev));
            if (ev) begin
                p = popped % FR;
                chk("px_rgb", 32'({px_r, px_g, px_b}), 32'(q[0].px));
                chk("px_sof", 32'(px_sof), 32'(p == 0));
                chk("px_eol", 32'(px_eol), 32'((p % W) == W - 1));
                chk("px_eof", 32'(px_eof), 32'(p == FR - 1));
            end else begin
                chk("px_markers_idle", 32'({px_sof, px_eol, px_eof}), 32'(0));
            end
            if (frame_phase && px_valid && px_ready) begin
                if (px_eof) eof_cnt++;
                if (px_eol) eol_cnt++;
                if (px_sof) sof_cnt++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [19:0] a, input logic [31:0] d, input logic [3:0] be);
        int   budget;
        logic w;
        avl_write      = 1'b1;
        avl_address    = a;
        avl_writedata  = d;
        avl_byteenable = be;
        budget         = 0;
        do begin
            w = avl_waitrequest;
            cyc();
            budget++;
        end while (w && budget < 200);
        if (w) chk("wr_timeout", 32'(w), 32'(0));
        avl_write = 1'b0;
    endtask

    task automatic rd(output logic [31:0] v);
        avl_read = 1'b1;
        cyc();
        avl_read = 1'b0;
        v = avl_readdata;
        $display("status read: %08h (level %0d, be_err %0d, seq_err %0d)", v, v[15:0], v[30], v[31]);
    endtask

    task automatic rst();
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [19:0] seq_addr;
        logic        was_acc;

        reset_n = 1'b0; avl_address = '0; avl_write = 1'b0; avl_writedata = '0;
        avl_byteenable = 4'hF; avl_read = 1'b0; err_clr = 1'b0; px_ready = 1'b0;
        repeat (3) cyc();
        chk("rst_px_valid", 32'(px_valid), 32'(0));
        chk("rst_waitrequest", 32'(avl_waitrequest), 32'(0));
        chk("rst_readdatavalid", 32'(avl_readdatavalid), 32'(0));
        chk("rst_readdata", avl_readdata, 32'(0));
        chk("rst_px_data", 32'({px_r, px_g, px_b, px_sof, px_eol, px_eof}), 32'(0));
        reset_n = 1'b1;
        $display("phase: three-pixel stream");

        wr(20'd0, 32'h0011_2233, 4'hF);
        chk("lat_not_yet", 32'(px_valid), 32'(0));
        cyc();
        chk("lat_valid", 32'(px_valid), 32'(1));
        chk("p0_rgb", 32'({px_r, px_g, px_b}), 32'h0011_2233);
        chk("p0_sof", 32'(px_sof), 32'(1));
        wr(20'd1, 32'h0044_5566, 4'hF);
        wr(20'd2, 32'h0077_8899, 4'hF);
        px_ready = 1'b1;
        cyc();
        chk("p1_rgb", 32'({px_r, px_g, px_b}), 32'h0044_5566);
        chk("p1_sof", 32'(px_sof), 32'(0));
        cyc();
        chk("p2_rgb", 32'({px_r, px_g, px_b}), 32'h0077_8899);
        cyc();
        chk("drained", 32'(px_valid), 32'(0));

        $display("phase: fill to full");
        rst();
        px_ready = 1'b0;
        for (int i = 0; i < D; i++) wr(20'(i), $urandom, 4'hF);
        chk("full_wait", 32'(avl_waitrequest), 32'(1));
        avl_write = 1'b1; avl_address = 20'(D); avl_writedata = 32'h00C0_FFEE; avl_byteenable = 4'hF;
        cyc();
        cyc();
        chk("stall_wait", 32'(avl_waitrequest), 32'(1));
        px_ready = 1'b1;
        cyc();
        px_ready = 1'b0;
        chk("pop_frees", 32'(avl_waitrequest), 32'(0));
        cyc();
        chk("px65_full_again", 32'(avl_waitrequest), 32'(1));
        avl_write = 1'b0;
        rd(v);
        chk("full_level", 32'(v[15:0]), 32'(64));
        px_ready = 1'b1;
        repeat (70) cyc();
        px_ready = 1'b0;

        $display("phase: byteenable error");
        wr(20'd65, 32'h00AB_CDEF, 4'h7);
        chk("be_no_wait", 32'(avl_waitrequest), 32'(0));
        repeat (3) cyc();
        chk("be_no_pixel", 32'(px_valid), 32'(0));
        rd(v);
        chk("be_flag", 32'(v[30]), 32'(1));
        chk("be_level", 32'(v[15:0]), 32'(0));
        err_clr = 1'b1; cyc(); err_clr = 1'b0;
        rd(v);
        chk("be_cleared", 32'(v[30]), 32'(0));
        err_clr = 1'b1;
        wr(20'd65, 32'h0012_3456, 4'h3);
        err_clr = 1'b0;
        rd(v);
        chk("be_error_wins", 32'(v[30]), 32'(1));
        err_clr = 1'b1; cyc(); err_clr = 1'b0;

        $display("phase: address sequence");
        px_ready = 1'b1;
        rst();
        wr(20'd0, 32'h0001_0203, 4'hF);
        wr(20'd5, 32'h0004_0506, 4'hF);
        repeat (3) cyc();
        rd(v);
`ifdef RGB_IN_SEQ_CHECK_EN
        chk("seq_flag", 32'(v[31]), 32'(1));
`else
        chk("seq_flag_off", 32'(v[31]), 32'(0));
`endif
        err_clr = 1'b1; cyc(); err_clr = 1'b0;
        rd(v);
        chk("seq_cleared", 32'(v[31]), 32'(0));

        $display("phase: reset mid-frame");
        px_ready = 1'b0;
        for (int i = 0; i < 10; i++) wr(20'(6 + i), $urandom, 4'hF);
        repeat (2) cyc();
        chk("pre_rst_valid", 32'(px_valid), 32'(1));
        rst();
        chk("mid_rst_valid", 32'(px_valid), 32'(0));
        rd(v);
        chk("mid_rst_level", 32'(v[15:0]), 32'(0));
        px_ready = 1'b1;
        wr(20'd0, 32'h00A1_B2C3, 4'hF);
        cyc();
        chk("post_rst_sof", 32'(px_sof), 32'(1));
        chk("post_rst_rgb", 32'({px_r, px_g, px_b}), 32'h00A1_B2C3);
        cyc();

        $display("phase: random traffic");
        seq_addr = 20'd1;
        for (int i = 0; i < 2000; i++) begin
            avl_write      = 1'($urandom_range(0, 3) != 0);
            avl_byteenable = ($urandom_range(0, 15) == 0) ? 4'h7 : 4'hF;
            avl_address    = ($urandom_range(0, 9) == 0) ? 20'($urandom_range(0, FR - 1)) : seq_addr;
            avl_writedata  = $urandom;
            avl_read       = 1'($urandom_range(0, 7) == 0);
            err_clr        = 1'($urandom_range(0, 15) == 0);
            px_ready       = (i < 1000) ? 1'($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 3) != 0);
            reset_n        = 1'($urandom_range(0, 499) != 0);
            was_acc        = avl_write && !avl_waitrequest && (avl_byteenable == 4'hF);
            cyc();
            if (!reset_n) seq_addr = '0;
            else if (was_acc) seq_addr = (avl_address >= 20'(FR - 1)) ? '0 : avl_address + 20'd1;
        end
        avl_write = 1'b0; avl_read = 1'b0; err_clr = 1'b0; reset_n = 1'b1;
        avl_byteenable = 4'hF;

        $display("phase: full frame");
        rst();
        frame_phase = 1'b1;
        px_ready    = 1'b1;
        for (int i = 0; i <= FR; i++) wr(20'(i % FR), $urandom, 4'hF);
        repeat (4) cyc();
        frame_phase = 1'b0;
        chk("frame_eof_count", 32'(eof_cnt), 32'(1));
        chk("frame_eol_count", 32'(eol_cnt), 32'(240));
        chk("frame_sof_count", 32'(sof_cnt), 32'(2));

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/rgb_in_stream_bridge.md
# rgb_in_stream_bridge

Avalon-MM slave on the host-facing `avl_rgb_data_in` port (20-bit address, 32-bit data, 4-bit byteenable) that accepts packed RGB pixel words written by the host over PCIe. It buffers them in a FIFO and emits a ready/valid pixel stream with frame markers to the first convolution stage of the depth-estimation network. It is the stage immediately downstream of the Qsys interconnect on the RGB input path.

## Interface
- `IMG_W`, 320, pixels per line
- `IMG_H`, 240, lines per frame
- `FIFO_DEPTH`, 64, pixel FIFO depth (power of two, ≥ 4)
- `clk`  in  1  user clock (the Qsys `clk_user_out` domain)
- `reset_n`  in  1  reset: one clock, synchronous, active-low
- `avl_address`  in  20  pixel index within the frame
- `avl_write`  in  1  write strobe
- `avl_writedata`  in  32  [23:16]=R, [15:8]=G, [7:0]=B, [31:24] ignored
- `avl_byteenable`  in  4  must be 4'hF for pixel writes
- `avl_read`  in  1  status read strobe
- `avl_readdata`  out  32  status word
- `avl_readdatavalid`  out  1  read response strobe
- `avl_waitrequest`  out  1  back-pressure
- `err_clr`  in  1  one-cycle pulse; clears sticky error flags
- `px_valid`  out  1  pixel stream valid
- `px_ready`  in  1  pixel stream ready
- `px_r`, `px_g`, `px_b`  out  8 each  pixel components
- `px_sof`, `px_eol`, `px_eof`  out  1 each  start of frame, end of line, end of frame (qualified by `px_valid`)

## Operation
- Write accepted when `avl_write && !avl_waitrequest`; bits [23:0] are pushed into the FIFO.
- `avl_waitrequest` = FIFO full (registered flag); a write while full is stalled, never dropped.
- Write with `avl_byteenable != 4'hF`: accepted (no stall), not pushed, sets sticky `be_err`.
- Output side: FIFO head is presented on `px_*`; pop on `px_valid && px_ready`.
- Output counters `x` (0..IMG_W-1) and `y` (0..IMG_H-1) advance on each pop: `px_sof` = (x==0 && y==0), `px_eol` = (x==IMG_W-1), `px_eof` = `px_eol` && (y==IMG_H-1). After eof, x and y wrap to 0.
- Read: `avl_readdata` = {`seq_err`, `be_err`, 14'b0, fill level zero-extended to 16 bits}; `avl_readdatavalid` pulses one cycle after `avl_read`. Reads never assert waitrequest.
- `err_clr` clears both sticky flags; a new error in the same cycle wins (flag stays set).

## Timing
- Reset values: `avl_waitrequest`=0, `avl_readdatavalid`=0, `avl_readdata`=0, `px_valid`=0, `px_*` data and markers 0, counters 0, flags 0, FIFO empty.
- Write-to-`px_valid` latency: 1 clock (pixel written at edge N is valid after edge N+1).
- `px_*` stay stable while `px_valid && !px_ready`.
- Full flag: push and pop in the same cycle while full is impossible (waitrequest already high); pop frees a slot and waitrequest drops the next cycle.
- Simultaneous push and pop at any other level: level unchanged.
- Reset mid-frame: FIFO flushed, counters to 0; the next accepted pixel is treated as sof.

## Configuration
- `RGB_IN_SEQ_CHECK_EN` defined: write-side expected-address counter (reset 0, wraps after IMG_W*IMG_H-1). An accepted pixel write with `avl_address` ≠ expected sets sticky `seq_err`; the pixel is still pushed, and expected resyncs to `avl_address`+1 (wrapping).
- Not defined: `avl_address` is ignored, `seq_err` reads as 0, no counter logic.

## Structure
- Shared package `depth_est_pkg`: `rgb_px_t` packed struct {r,g,b}, `IMG_W`/`IMG_H` defaults, status-word bit positions.
- One sub-module `rgb_in_fifo`: synchronous FIFO (push, pop, data, full, empty, level) with a registered output head; the top holds Avalon decode, error flags, and frame counters.

## Test plan
- Write 3 pixels 0x00112233, 0x00445566, 0x00778899 at addresses 0,1,2 with `px_ready`=1 -> stream R/G/B 11/22/33, 44/55/66, 77/88/99; first with sof=1; valid 1 cycle after each write.
- Hold `px_ready`=0, write 65 pixels -> waitrequest rises after 64th; raise ready for 1 cycle -> 65th accepted within 2 cycles; status read level = 64.
- Stream full 320×240 frame -> eol on every 320th pixel, eof exactly once on pixel 76799, next pixel has sof.
- With `RGB_IN_SEQ_CHECK_EN`, write address 0 then 5 -> status bit 31 = 1, both pixels streamed; `err_clr` -> bit 31 = 0.
- Write byteenable 4'h7 -> no pixel emitted, bit 30 = 1, no waitrequest.
- Assert `reset_n`=0 with 10 pixels buffered -> `px_valid`=0 next cycle, level 0, next write emits sof.
